llc_rst_flush_sequencer: RTL and testbench
==========================================

// Module: llc_rst_flush_sequencer
// PURPOSE
//  Sequences LLC reset and flush operations as a walk over every LLC set.
//  - Accepts a reset/flush command from the rst_tb channel.
//  - Raises rst_stall/flush_stall for the input decoder and supplies the current set (rst_flush_stalled_set).
//  - Advances one set per datapath completion pulse, then returns a completion response.
//  - Sits between the rst_tb input channel and the input decoder / LLC datapath.
// PARAMETERS
//  LLC_SET_BITS  9  width of set index; walk covers 2**LLC_SET_BITS sets
// PORTS
//  clk                    in   1             clock, all state updates on posedge
//  rst                    in   1             asynchronous reset, active-low
//  rst_tb_valid           in   1             reset/flush command valid
//  rst_tb_is_flush        in   1             1 = flush, 0 = reset; sampled with rst_tb_valid
//  rst_tb_ready           out  1             command accepted when valid & ready
//  set_done               in   1             datapath finished current set (1-cycle pulse)
//  rst_stall              out  1             reset walk in progress
//  flush_stall            out  1             flush walk in progress
//  rst_flush_stalled_set  out  LLC_SET_BITS  set currently being reset/flushed
//  rst_flush_done_valid   out  1             walk complete, response valid
//  rst_flush_done_is_flush out 1             mode of completed walk
//  rst_flush_done_ready   in   1             consumer accepts response
//  busy                   out  1             state != IDLE
// BEHAVIOUR
//  Reset (rst=0, async):
//  - State goes to IDLE; set counter = 0; mode = 0.
//  - All outputs are 0 except rst_tb_ready = 1.
//  State IDLE:
//  - rst_tb_ready = 1, driven combinationally from state only; it never depends on rst_tb_valid.
//  - On rst_tb_valid at posedge: latch rst_tb_is_flush into mode, clear counter to 0, go to WALK.
//  - The first stall is visible in the cycle after the handshake.
//  - set_done is ignored.
//  State WALK:
//  - rst_tb_ready = 0.
//  - rst_stall = ~mode; flush_stall = mode; rst_flush_stalled_set = counter (registered).
//  - set_done with counter != all-ones: counter += 1 at the edge; the next set is visible the following cycle.
//  - set_done with counter == all-ones:
//    - Go to DONE and clear both stalls at the same edge.
//    - Counter wraps to 0 (LLC_SET_BITS-wide modulo add, no carry out).
//  - Without set_done, counter and stalls hold indefinitely.
//  - At most one set advance per cycle.
//  State DONE:
//  - rst_flush_done_valid = 1 and rst_flush_done_is_flush = mode, both stable until accepted.
//  - Stalls are 0; rst_tb_ready = 0; set_done is ignored.
//  - On rst_flush_done_ready: go to IDLE.
//  - A new command can be accepted on the cycle after the return to IDLE; there is no IDLE bypass.
//  Boundary conditions:
//  - rst_tb_valid held high outside IDLE: not accepted; the command stays pending upstream.
//  - set_done in the same cycle as the IDLE handshake: ignored. The walk always starts at set 0.
//  - LLC_SET_BITS=1: the walk takes exactly 2 set_done pulses.
//  - Async reset mid-walk: stalls drop immediately, no done response is produced, state returns to IDLE.
//  - rst_stall and flush_stall are never both 1.
//  - Stall outputs and rst_flush_done_valid are never 1 in the same cycle.
//  Latency: handshake -> stall is 1 cycle; last set_done -> done_valid is 1 cycle.
//  Minimum walk length: 2**LLC_SET_BITS cycles after the stall rises.
// TESTING
//  1. Reset values: hold rst=0 for 3 cycles, then release.
//     -> rst_tb_ready=1; all other outputs 0; busy=0.
//  2. Reset walk, LLC_SET_BITS=2: send valid with is_flush=0, then 4 set_done pulses spaced 2 cycles apart.
//     -> rst_stall=1 with set = 0,1,2,3.
//     -> After the 4th pulse: stall=0, done_valid=1, done_is_flush=0.
//  3. Flush with backpressure: flush command, 4 back-to-back set_done pulses, rst_flush_done_ready=0 for 5 cycles.
//     -> done_valid and done_is_flush=1 held for 5 cycles; IDLE one cycle after ready=1.
//  4. Spurious and early inputs:
//     -> set_done in IDLE or DONE leaves the counter unchanged.
//     -> set_done coincident with the IDLE handshake: the walk still begins at set 0.
//     -> rst_tb_valid during WALK: ready=0 and no second walk starts.
//  5. Async reset mid-walk at set 2: assert rst=0 between edges.
//     -> rst_stall=0 immediately; after release, IDLE with set=0 and done_valid never pulses.
//  6. Back-to-back commands: reset walk, done accepted, flush command held valid.
//     -> Accepted the cycle after return to IDLE; flush_stall=1 at set 0 and rst_stall stays 0.

Source files
------------

// File: rtl/llc_rst_flush_sequencer_if.sv
// Handshake and status bundle between the rst_tb command channel, the
// input decoder / LLC datapath and the reset/flush sequencer.
//   rst_tb_valid / rst_tb_is_flush / rst_tb_ready      : command channel
//   set_done                                           : datapath finished current set
//   rst_stall / flush_stall / rst_flush_stalled_set    : walk status to the decoder
//   rst_flush_done_valid / _is_flush / _ready          : completion response channel
//   busy                                               : sequencer not idle
// The "slave" modport is the sequencer; "master" is its environment.
interface llc_rst_flush_sequencer_if #(
    parameter int LLC_SET_BITS = 9
);
    logic                    rst_tb_valid;
    logic                    rst_tb_is_flush;
    logic                    rst_tb_ready;
    logic                    set_done;
    logic                    rst_stall;
    logic                    flush_stall;
    logic [LLC_SET_BITS-1:0] rst_flush_stalled_set;
    logic                    rst_flush_done_valid;
    logic                    rst_flush_done_is_flush;
    logic                    rst_flush_done_ready;
    logic                    busy;

    modport slave (
        input  rst_tb_valid, rst_tb_is_flush, set_done, rst_flush_done_ready,
        output rst_tb_ready, rst_stall, flush_stall, rst_flush_stalled_set,
               rst_flush_done_valid, rst_flush_done_is_flush, busy
    );

    modport master (
        output rst_tb_valid, rst_tb_is_flush, set_done, rst_flush_done_ready,
        input  rst_tb_ready, rst_stall, flush_stall, rst_flush_stalled_set,
               rst_flush_done_valid, rst_flush_done_is_flush, busy
    );
endinterface

// File: rtl/llc_rst_flush_sequencer.sv
// Sequences an LLC reset or flush as a walk over all 2**LLC_SET_BITS sets.
// A command accepted in IDLE starts a walk at set 0; each set_done pulse
// advances one set; after the last set a completion response is held until
// the consumer accepts it.
// Ports:
//   clk  : clock, all state updates on posedge
//   rst  : asynchronous reset, active-low
//   bus  : llc_rst_flush_sequencer_if.slave (command, stall, done channels)
module llc_rst_flush_sequencer #(
    parameter int LLC_SET_BITS = 9
) (
    input  logic                            clk,
    input  logic                            rst,
    llc_rst_flush_sequencer_if.slave        bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WALK = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                  state;
    logic                    mode;     // 1 = flush, 0 = reset
    logic [LLC_SET_BITS-1:0] set_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            mode    <= 1'b0;
            set_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // set_done is deliberately ignored here, so a pulse
                    // coincident with the handshake cannot skip set 0.
                    if (bus.rst_tb_valid) begin
                        mode    <= bus.rst_tb_is_flush;
                        set_cnt <= '0;
                        state   <= WALK;
                    end
                end
                WALK: begin
                    if (bus.set_done) begin
                        // Modulo add: the last set wraps the counter back to 0.
                        set_cnt <= set_cnt + 1'b1;
                        if (set_cnt == {LLC_SET_BITS{1'b1}}) begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (bus.rst_flush_done_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs decode only registered state, so they are glitch-free and an
    // asynchronous reset clears the stalls immediately.
    assign bus.rst_tb_ready            = (state == IDLE);
    assign bus.rst_stall               = (state == WALK) && !mode;
    assign bus.flush_stall             = (state == WALK) &&  mode;
    assign bus.rst_flush_stalled_set   = (state == WALK) ? set_cnt : '0;
    assign bus.rst_flush_done_valid    = (state == DONE);
    assign bus.rst_flush_done_is_flush = (state == DONE) && mode;
    assign bus.busy                    = (state != IDLE);

endmodule

// File: tb/tb_llc_rst_flush_sequencer.sv
module tb_llc_rst_flush_sequencer;

    localparam int SB = 2;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    llc_rst_flush_sequencer_if #(.LLC_SET_BITS(SB)) bus ();

    llc_rst_flush_sequencer #(.LLC_SET_BITS(SB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next active edge; inputs change and outputs
    // are sampled here, away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.rst_tb_valid = 1'b0;
        bus.rst_tb_is_flush = 1'b0;
        bus.set_done = 1'b0;
        bus.rst_flush_done_ready = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        checks++; if (bus.rst_tb_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", bus.rst_tb_ready); end
        checks++; if ({bus.rst_stall, bus.flush_stall, bus.rst_flush_done_valid, bus.rst_flush_done_is_flush, bus.busy} !== 5'b0)
            begin errors++; $display("FAIL reset_flags got %b want 00000", {bus.rst_stall, bus.flush_stall, bus.rst_flush_done_valid, bus.rst_flush_done_is_flush, bus.busy}); end
        checks++; if (bus.rst_flush_stalled_set !== 2'd0) begin errors++; $display("FAIL reset_set got %0d want 0", bus.rst_flush_stalled_set); end
    endtask

    task automatic test_reset_walk();
        bus.rst_tb_valid = 1'b1; bus.rst_tb_is_flush = 1'b0;
        tick();
        bus.rst_tb_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            checks++; if (bus.rst_stall !== 1'b1 || bus.flush_stall !== 1'b0 || bus.rst_tb_ready !== 1'b0)
                begin errors++; $display("FAIL walk_stall k=%0d got rst=%b flush=%b rdy=%b want 1 0 0", k, bus.rst_stall, bus.flush_stall, bus.rst_tb_ready); end
            checks++; if (bus.rst_flush_stalled_set !== 2'(k)) begin errors++; $display("FAIL walk_set got %0d want %0d", bus.rst_flush_stalled_set, k); end
            bus.set_done = 1'b1;
            tick();
            bus.set_done = 1'b0;
            if (k < 3) begin
                checks++; if (bus.rst_flush_stalled_set !== 2'(k + 1)) begin errors++; $display("FAIL walk_hold got %0d want %0d", bus.rst_flush_stalled_set, k + 1); end
                tick();
            end
        end
        checks++; if (bus.rst_stall !== 1'b0 || bus.rst_flush_done_valid !== 1'b1 || bus.rst_flush_done_is_flush !== 1'b0)
            begin errors++; $display("FAIL walk_done got stall=%b dv=%b df=%b want 0 1 0", bus.rst_stall, bus.rst_flush_done_valid, bus.rst_flush_done_is_flush); end
        bus.rst_flush_done_ready = 1'b1;
        tick();
        bus.rst_flush_done_ready = 1'b0;
        checks++; if (bus.busy !== 1'b0 || bus.rst_tb_ready !== 1'b1 || bus.rst_flush_done_valid !== 1'b0)
            begin errors++; $display("FAIL walk_idle got busy=%b rdy=%b dv=%b want 0 1 0", bus.busy, bus.rst_tb_ready, bus.rst_flush_done_valid); end
    endtask

    task automatic test_flush_backpressure();
        bus.rst_tb_valid = 1'b1; bus.rst_tb_is_flush = 1'b1;
        tick();
        bus.rst_tb_valid = 1'b0; bus.rst_tb_is_flush = 1'b0;
        bus.set_done = 1'b1;
        for (int k = 0; k < 4; k++) begin
            checks++; if (bus.flush_stall !== 1'b1 || bus.rst_stall !== 1'b0 || bus.rst_flush_stalled_set !== 2'(k))
                begin errors++; $display("FAIL flush_walk k=%0d got fs=%b rs=%b set=%0d want 1 0 %0d", k, bus.flush_stall, bus.rst_stall, bus.rst_flush_stalled_set, k); end
            tick();
        end
        bus.set_done = 1'b0;
        for (int c = 0; c < 5; c++) begin
            checks++; if (bus.rst_flush_done_valid !== 1'b1 || bus.rst_flush_done_is_flush !== 1'b1 || bus.flush_stall !== 1'b0)
                begin errors++; $display("FAIL flush_hold c=%0d got dv=%b df=%b fs=%b want 1 1 0", c, bus.rst_flush_done_valid, bus.rst_flush_done_is_flush, bus.flush_stall); end
            tick();
        end
        bus.rst_flush_done_ready = 1'b1;
        tick();
        bus.rst_flush_done_ready = 1'b0;
        checks++; if (bus.busy !== 1'b0 || bus.rst_flush_done_valid !== 1'b0)
            begin errors++; $display("FAIL flush_idle got busy=%b dv=%b want 0 0", bus.busy, bus.rst_flush_done_valid); end
    endtask

    task automatic test_spurious();
        // set_done in IDLE, then set_done coincident with the handshake
        bus.set_done = 1'b1;
        tick();
        bus.rst_tb_valid = 1'b1; bus.rst_tb_is_flush = 1'b0;
        tick();
        bus.set_done = 1'b0;
        bus.rst_tb_is_flush = 1'b1;      // valid held high during the walk
        checks++; if (bus.rst_flush_stalled_set !== 2'd0 || bus.rst_stall !== 1'b1)
            begin errors++; $display("FAIL early_start got set=%0d rs=%b want 0 1", bus.rst_flush_stalled_set, bus.rst_stall); end
        tick();
        checks++; if (bus.rst_tb_ready !== 1'b0 || bus.flush_stall !== 1'b0 || bus.rst_flush_stalled_set !== 2'd0)
            begin errors++; $display("FAIL walk_valid got rdy=%b fs=%b set=%0d want 0 0 0", bus.rst_tb_ready, bus.flush_stall, bus.rst_flush_stalled_set); end
        bus.set_done = 1'b1;
        repeat (4) tick();
        // now in DONE with valid still held; extra set_done must be ignored
        tick();
        bus.set_done = 1'b0;
        checks++; if (bus.rst_flush_done_valid !== 1'b1 || bus.rst_flush_done_is_flush !== 1'b0 || bus.rst_tb_ready !== 1'b0)
            begin errors++; $display("FAIL done_ignore got dv=%b df=%b rdy=%b want 1 0 0", bus.rst_flush_done_valid, bus.rst_flush_done_is_flush, bus.rst_tb_ready); end
        bus.rst_tb_valid = 1'b0; bus.rst_tb_is_flush = 1'b0;
        bus.rst_flush_done_ready = 1'b1;
        tick();
        bus.rst_flush_done_ready = 1'b0;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL spur_idle got busy=%b want 0", bus.busy); end
    endtask

    task automatic test_async_reset();
        logic saw_done;
        bus.rst_tb_valid = 1'b1; bus.rst_tb_is_flush = 1'b0;
        tick();
        bus.rst_tb_valid = 1'b0;
        bus.set_done = 1'b1;
        repeat (2) tick();
        bus.set_done = 1'b0;
        checks++; if (bus.rst_flush_stalled_set !== 2'd2) begin errors++; $display("FAIL async_pre got set=%0d want 2", bus.rst_flush_stalled_set); end
        #2 rst = 1'b0;
        #1;
        checks++; if (bus.rst_stall !== 1'b0 || bus.busy !== 1'b0 || bus.rst_tb_ready !== 1'b1)
            begin errors++; $display("FAIL async_drop got rs=%b busy=%b rdy=%b want 0 0 1", bus.rst_stall, bus.busy, bus.rst_tb_ready); end
        tick();
        rst = 1'b1;
        saw_done = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (bus.rst_flush_done_valid !== 1'b0) saw_done = 1'b1;
        end
        checks++; if (saw_done !== 1'b0 || bus.busy !== 1'b0 || bus.rst_flush_stalled_set !== 2'd0)
            begin errors++; $display("FAIL async_after got dv_seen=%b busy=%b set=%0d want 0 0 0", saw_done, bus.busy, bus.rst_flush_stalled_set); end
    endtask

    task automatic test_back_to_back();
        bus.rst_tb_valid = 1'b1; bus.rst_tb_is_flush = 1'b0;
        tick();
        bus.rst_tb_valid = 1'b0;
        bus.set_done = 1'b1;
        repeat (4) tick();
        bus.set_done = 1'b0;
        bus.rst_tb_valid = 1'b1; bus.rst_tb_is_flush = 1'b1;
        bus.rst_flush_done_ready = 1'b1;
        tick();
        bus.rst_flush_done_ready = 1'b0;
        checks++; if (bus.busy !== 1'b0 || bus.rst_tb_ready !== 1'b1)
            begin errors++; $display("FAIL b2b_idle got busy=%b rdy=%b want 0 1", bus.busy, bus.rst_tb_ready); end
        tick();
        bus.rst_tb_valid = 1'b0; bus.rst_tb_is_flush = 1'b0;
        checks++; if (bus.flush_stall !== 1'b1 || bus.rst_stall !== 1'b0 || bus.rst_flush_stalled_set !== 2'd0)
            begin errors++; $display("FAIL b2b_flush got fs=%b rs=%b set=%0d want 1 0 0", bus.flush_stall, bus.rst_stall, bus.rst_flush_stalled_set); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_reset_walk();
        test_flush_backpressure();
        test_spurious();
        test_async_reset();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
